// File: rtl/fixed_point_mac_stream_if.sv
// Operand/result stream bundle for the fixed-point MAC.
//   in_valid/in_ready/in_a/in_b/in_last : operand pair stream (Q15.16, signed)
//   out_valid/out_ready                 : result handshake
//   out_data/out_overflow/out_count     : dot product, sticky saturation flag, term count
// master drives operands and out_ready; slave is the MAC engine.
interface fixed_point_mac_stream_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_overflow;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_overflow, out_count
  );
endinterface

// File: rtl/fixed_point_mac_stream.sv
// Streaming Q15.16 dot-product engine. Accepts one (a,b) pair per cycle, forms a
// saturated product in stage P, accumulates with saturation in stage A, and on the
// last term presents sum / sticky overflow / term count until the consumer takes it.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of fixed_point_mac_stream_if (operand stream in, result out)
module fixed_point_mac_stream #(
  parameter int unsigned CNT_W = 16
) (
  input logic                     clk,
  input logic                     rst,
  fixed_point_mac_stream_if.slave bus
);

  typedef enum logic [1:0] {StRun, StFlush, StHold} state_e;

  localparam logic [31:0] SatPos = 32'h7FFF_FFFF;
  localparam logic [31:0] SatNeg = 32'h8000_0000;

  state_e state_q, state_d;

  logic             accept;
  logic             p_valid_q, p_ovf_q, p_last_q;
  logic [31:0]      p_prod_q;
  logic [31:0]      acc_q;
  logic             ovf_acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q, out_ovf_q;
  logic [31:0]      out_data_q;
  logic [CNT_W-1:0] out_count_q;

  // Multiply: full 64-bit signed product, rescaled by the 16 fraction bits.
  logic signed [63:0] a_ext, b_ext, mul_full;
  logic [47:0]        mul_shift;
  logic               prod_ovf;
  logic [31:0]        prod_sat;
  logic               unused_mul;

  always_comb begin
    a_ext     = {{32{bus.in_a[31]}}, bus.in_a};
    b_ext     = {{32{bus.in_b[31]}}, bus.in_b};
    mul_full  = a_ext * b_ext;
    mul_shift = mul_full[63:16];
    // Fits in 32 bits only if bits [47:31] are all sign copies.
    prod_ovf  = ~((&mul_shift[47:31]) | ~(|mul_shift[47:31]));
    if (prod_ovf) prod_sat = mul_shift[47] ? SatNeg : SatPos;
    else          prod_sat = mul_shift[31:0];
  end
  assign unused_mul = ^mul_full[15:0];

  // Accumulate: 33-bit sum, clamp when the carry-out disagrees with the sign bit.
  logic [32:0]      sum_wide;
  logic             add_ovf;
  logic [31:0]      sum_sat;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    sum_wide = {acc_q[31], acc_q} + {p_prod_q[31], p_prod_q};
    add_ovf  = sum_wide[32] ^ sum_wide[31];
    if (add_ovf) sum_sat = sum_wide[32] ? SatNeg : SatPos;
    else         sum_sat = sum_wide[31:0];
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  assign bus.in_ready     = (state_q == StRun) & ~rst;
  assign accept           = bus.in_valid & bus.in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_overflow = out_ovf_q;
  assign bus.out_count    = out_count_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (accept && bus.in_last) state_d = StFlush;
      StFlush: state_d = StHold;
      StHold:  if (bus.out_ready) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StRun;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid_q   <= 1'b0;
      p_ovf_q     <= 1'b0;
      p_last_q    <= 1'b0;
      p_prod_q    <= '0;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      p_valid_q <= accept;
      if (accept) begin
        p_prod_q <= prod_sat;
        p_ovf_q  <= prod_ovf;
        p_last_q <= bus.in_last;
      end
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      if (p_valid_q) begin
        if (p_last_q) begin
          out_data_q  <= sum_sat;
          out_ovf_q   <= ovf_acc_q | p_ovf_q | add_ovf;
          out_count_q <= cnt_inc;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          ovf_acc_q   <= 1'b0;
          cnt_q       <= '0;
        end else begin
          acc_q     <= sum_sat;
          ovf_acc_q <= ovf_acc_q | p_ovf_q | add_ovf;
          cnt_q     <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_mac_stream.sv
// Directed bench for fixed_point_mac_stream: hand-computed vectors, immediate assertions.
module tb_fixed_point_mac_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fixed_point_mac_stream_if bus ();

  fixed_point_mac_stream dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair and hold it until the DUT takes it (bounded).
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.in_ready) ok = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("accepted", 64'(ok), 64'd1);
  endtask

  // Called right after the last beat's accept edge: result must appear one edge later.
  task automatic wait_result(input string tag, input logic [31:0] data, input logic ovf,
                             input logic [15:0] cnt);
    int n;
    n = 0;
    while (!bus.out_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd1);
    check({tag, "_data"}, 64'(bus.out_data), 64'(data));
    check({tag, "_ovf"}, 64'(bus.out_overflow), 64'(ovf));
    check({tag, "_count"}, 64'(bus.out_count), 64'(cnt));
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_ovf", 64'(bus.out_overflow), 64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // T1: 1.5*2 + 0.5*(-1) = 2.5
    send(32'h0001_8000, 32'h0002_0000, 1'b0);
    send(32'h0000_8000, 32'hFFFF_0000, 1'b1);
    check("t1_flush_ready", 64'(bus.in_ready), 64'd0);
    wait_result("t1", 32'h0002_8000, 1'b0, 16'd2);
    handshake("t1");

    // T2: product clamps at +rail, then -1 pulls it back off
    send(32'h7FFF_0000, 32'h0002_0000, 1'b0);
    send(32'hFFFF_0000, 32'h0001_0000, 1'b1);
    wait_result("t2", 32'h7FFE_FFFF, 1'b1, 16'd2);
    handshake("t2");

    // T3: -32768 exact, then -1 saturates the add at -rail
    send(32'h8000_0000, 32'h0001_0000, 1'b0);
    send(32'hFFFF_0000, 32'h0001_0000, 1'b1);
    wait_result("t3", 32'h8000_0000, 1'b1, 16'd2);
    handshake("t3");

    // T4: output stall with a pending pair that must not be consumed
    send(32'h0001_0000, 32'h0005_0000, 1'b1);
    wait_result("t4a", 32'h0005_0000, 1'b0, 16'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h0003_0000;
    bus.in_b     = 32'h0003_0000;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", 64'(bus.out_valid), 64'd1);
      check("t4_hold_data", 64'(bus.out_data), 64'h0005_0000);
      check("t4_hold_count", 64'(bus.out_count), 64'd1);
      check("t4_hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    handshake("t4");
    bus.in_valid = 1'b0;
    send(32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_result("t4b", 32'h0001_0000, 1'b0, 16'd1);
    handshake("t4b");

    // T5: back-to-back single-beat vectors
    send(32'h0002_0000, 32'h0003_0000, 1'b1);
    wait_result("t5a", 32'h0006_0000, 1'b0, 16'd1);
    handshake("t5a");
    send(32'hFFFF_0000, 32'h0001_0000, 1'b1);
    wait_result("t5b", 32'hFFFF_0000, 1'b0, 16'd1);
    handshake("t5b");

    // T6: reset mid-vector discards the partial sum and the pipe stage
    send(32'h0001_0000, 32'h0002_0000, 1'b0);
    send(32'h0001_0000, 32'h0003_0000, 1'b0);
    rst = 1'b1;
    #1;
    check("t6_rst_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t6_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("t6_no_out_valid", 64'(bus.out_valid), 64'd0);
      tick();
    end
    send(32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_result("t6", 32'h0001_0000, 1'b0, 16'd1);
    handshake("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
